// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM states and error convention for alu_arbiter
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  // unsupported op: result forced to 0, zero flag 0, err flag 1
  function automatic logic op_err(input logic [3:0] op);
    return !(op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB});
  endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bus of the shared ALU
interface alu_arbiter_if #(parameter int DATA_W = 32, parameter int NUM_REQ = 2) ();
  localparam int ID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][3:0]        req_op;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_b;
  logic                           resp_valid;
  logic                           resp_ready;
  logic [ID_W-1:0]                resp_id;
  logic [DATA_W-1:0]              resp_data;
  logic                           resp_zero;
  logic                           resp_err;
  modport master (output req_valid, req_op, req_a, req_b, resp_ready,
                  input req_ready, resp_valid, resp_id, resp_data, resp_zero, resp_err);
  modport slave (input req_valid, req_op, req_a, req_b, resp_ready,
                 output req_ready, resp_valid, resp_id, resp_data, resp_zero, resp_err);
endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, priority passes past the winner on each grant
module rr_arbiter #(parameter int NUM_REQ = 2) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic [NUM_REQ-1:0]         valid_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id_o
);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [ID_W-1:0] ptr_q, idx;
  logic            found;
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    gnt_id_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && valid_i[idx]) begin
        found    = 1'b1;
        gnt_id_o = idx;
      end
    end
    gnt_o = (en_i && found) ? (NUM_REQ'(1) << gnt_id_o) : '0;
  end
  always_ff @(posedge clk)
    if (rst) ptr_q <= '0;
    else if (|gnt_o) ptr_q <= (gnt_id_o == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_o + 1'b1;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin shared ALU, IDLE->EXEC->RESP; ALU_ARB_PERF_EN adds per-requester grant counters
module alu_arbiter import alu_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int NUM_REQ = 2
) (
  input logic clk,
  input logic rst,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_PERF_EN
  , output logic [NUM_REQ-1:0][31:0] perf_grant_cnt
`endif
);
  localparam int ID_W = $clog2(NUM_REQ);
  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_id, id_q;
  logic [3:0]          op_q;
  logic [DATA_W-1:0]   a_q, b_q, res_q, res_d;
  logic                zero_q, zero_d, err_q, err_d;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk(clk), .rst(rst), .en_i(state_q == IDLE && !rst),
    .valid_i(bus.req_valid), .gnt_o(gnt), .gnt_id_o(gnt_id)
  );
  always_comb begin
    state_d = state_q == IDLE ? (|gnt ? EXEC : IDLE) :
              state_q == EXEC ? RESP : (bus.resp_ready ? IDLE : RESP);
    res_d   = op_q == ALU_AND ? a_q & b_q :
              op_q == ALU_OR  ? a_q | b_q :
              op_q == ALU_ADD ? a_q + b_q :
              op_q == ALU_SUB ? a_q - b_q : '0;
    zero_d  = op_q == ALU_SUB && a_q == b_q;
    err_d   = op_err(op_q);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (|gnt) begin
        op_q <= bus.req_op[gnt_id];
        a_q  <= bus.req_a[gnt_id];
        b_q  <= bus.req_b[gnt_id];
        id_q <= gnt_id;
      end
      if (state_q == EXEC) begin
        res_q  <= res_d;
        zero_q <= zero_d;
        err_q  <= err_d;
      end
    end
  assign bus.req_ready  = gnt;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_id    = id_q;
  assign bus.resp_data  = res_q;
  assign bus.resp_zero  = zero_q;
  assign bus.resp_err   = err_q;
`ifdef ALU_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] cnt_q;
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_REQ; i++)
      if (rst) cnt_q[i] <= '0;
      else if (gnt[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
  assign perf_grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors for alu_arbiter (default 32-bit, two requesters)
module tb_alu_arbiter;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  alu_arbiter_if #(.DATA_W(32), .NUM_REQ(2)) bus ();
`ifdef ALU_ARB_PERF_EN
  logic [1:0][31:0] perf;
`endif
  alu_arbiter #(.DATA_W(32), .NUM_REQ(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef ALU_ARB_PERF_EN
    , .perf_grant_cnt(perf)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input int idx, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_d, input logic exp_z, input logic exp_e);
    logic [1:0] g;
    g = '0;
    g[idx] = 1'b1;
    bus.req_valid = g;
    bus.req_op[idx] = op;
    bus.req_a[idx] = a;
    bus.req_b[idx] = b;
    #1;
    check("grant", bus.req_ready, g);
    step();
    bus.req_valid = '0;
    #1;
    check("exec_ready", bus.req_ready, 0);
    check("exec_valid", bus.resp_valid, 0);
    step();
    check("resp_valid", bus.resp_valid, 1);
    check("resp_id", bus.resp_id, idx);
    check("resp_data", bus.resp_data, exp_d);
    check("resp_zero", bus.resp_zero, exp_z);
    check("resp_err", bus.resp_err, exp_e);
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    #1;
  endtask
  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.resp_ready = 1'b0;
    step();
    step();
    check("rst_ready", bus.req_ready, 0);
    check("rst_valid", bus.resp_valid, 0);
    check("rst_id", bus.resp_id, 0);
    check("rst_data", bus.resp_data, 0);
    check("rst_zero", bus.resp_zero, 0);
    check("rst_err", bus.resp_err, 0);
    rst = 1'b0;
    issue(0, ALU_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0);
    issue(1, ALU_SUB, 32'h1234, 32'h1234, 32'h0, 1'b1, 1'b0);
    issue(0, ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    issue(1, 4'b0101, 32'd3, 32'd3, 32'h0, 1'b0, 1'b1);
    issue(0, ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0);
    issue(1, ALU_OR, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0);
    // contention: pointer back at 0, both held valid, consumer always ready
    bus.req_op[0] = ALU_ADD; bus.req_a[0] = 32'd1;  bus.req_b[0] = 32'd2;
    bus.req_op[1] = ALU_ADD; bus.req_a[1] = 32'd10; bus.req_b[1] = 32'd20;
    bus.req_valid = 2'b11;
    bus.resp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("rr_grant", bus.req_ready, (k % 2) ? 2'b10 : 2'b01);
      step();
      check("rr_exec_ready", bus.req_ready, 0);
      step();
      check("rr_resp_id", bus.resp_id, k % 2);
      check("rr_resp_data", bus.resp_data, (k % 2) ? 32'd30 : 32'd3);
      step();
    end
    bus.req_valid = '0;
    bus.resp_ready = 1'b0;
    // backpressure on a req0 ADD
    bus.req_a[0] = 32'd100; bus.req_b[0] = 32'd23;
    bus.req_valid = 2'b01;
    #1;
    check("bp_grant", bus.req_ready, 2'b01);
    step();
    bus.req_valid = '0;
    step();
    bus.req_valid = 2'b11;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", bus.resp_valid, 1);
      check("bp_data", bus.resp_data, 32'd123);
      check("bp_id", bus.resp_id, 0);
      check("bp_ready", bus.req_ready, 0);
      step();
    end
    bus.req_valid = 2'b10;
    bus.req_a[1] = 32'd1; bus.req_b[1] = 32'd1;
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check("bp_release_valid", bus.resp_valid, 0);
    check("bp_release_grant", bus.req_ready, 2'b10);
    step();
    bus.req_valid = '0;
    step();
    check("pre_rst_valid", bus.resp_valid, 1);
    check("pre_rst_data", bus.resp_data, 32'd2);
    // reset while holding a response
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_data", bus.resp_data, 0);
`ifdef ALU_ARB_PERF_EN
    check("perf0_cleared", perf[0], 0);
    check("perf1_cleared", perf[1], 0);
`endif
    bus.req_valid = 2'b11;
    #1;
    check("rst_next_grant", bus.req_ready, 2'b01);
    step();
    bus.req_valid = '0;
`ifdef ALU_ARB_PERF_EN
    check("perf0_count", perf[0], 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
